// File: rtl/mips_bus_prefetch_pkg.sv
// Shared types and helpers for the MIPS Avalon bus interface unit with instruction prefetch.
package mips_bus_prefetch_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_IFETCH,
    BUS_DATA
  } bus_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // Reverse byte order of a 32-bit word (big-endian core <-> little-endian bus).
  function automatic logic [31:0] toggle_endianness(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mips_bus_prefetch_if.sv
// Avalon-MM master bus bundle between the bus interface unit and memory.
interface mips_bus_prefetch_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_prefetch_fifo.sv
// Synchronous FIFO holding prefetched {pc, instruction} pairs; clear has priority over push/pop.
module mips_bus_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_bus_prefetch.sv
// MIPS bus interface unit: one Avalon master shared by an instruction prefetch queue and
// core data accesses (data wins arbitration); flush redirects fetch and drops stale reads.
module mips_bus_prefetch
  import mips_bus_prefetch_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = RESET_VECTOR,
  parameter bit          SWAP_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_done,
  mips_bus_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  bus_state_t  state, state_n;
  logic [31:0] fetch_pc;
  logic        stale;
  logic        issue_data, issue_fetch;
  logic        xfer_done, fetch_done;

  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;
  logic [3:0]  be_q;

  logic [31:0] rdata_core, wdata_bus;

  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  generate
    if (SWAP_ENDIAN) begin : g_swap
      assign rdata_core = toggle_endianness(bus.readdata);
      assign wdata_bus  = toggle_endianness(d_writedata);
    end else begin : g_pass
      assign rdata_core = bus.readdata;
      assign wdata_bus  = d_writedata;
    end
  endgenerate

  assign bus.address    = addr_q;
  assign bus.read       = rd_q;
  assign bus.write      = wr_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;

  assign xfer_done  = (rd_q || wr_q) && !bus.waitrequest;
  assign fetch_done = (state == BUS_IFETCH) && xfer_done;

  // Flush wins over a same-cycle push; a stale fetch never lands in the queue.
  assign fifo_push = fetch_done && !stale && !flush && !fifo_full;
  assign fifo_pop  = instr_valid && instr_ready;

  mips_bus_prefetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({fetch_pc, rdata_core}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign instr_pc    = fifo_empty ? 32'h0 : fifo_head[63:32];

  always_comb begin
    state_n     = state;
    issue_data  = 1'b0;
    issue_fetch = 1'b0;
    unique case (state)
      BUS_IDLE: begin
        // No fetch is launched on a flush cycle: fetch_pc is about to change.
        if ((d_read || d_write) && !d_done) begin
          state_n    = BUS_DATA;
          issue_data = 1'b1;
        end else if (!flush && (fifo_count < DEPTH_C)) begin
          state_n     = BUS_IFETCH;
          issue_fetch = 1'b1;
        end
      end
      BUS_IFETCH: if (xfer_done) state_n = BUS_IDLE;
      BUS_DATA:   if (xfer_done) state_n = BUS_IDLE;
      default:    state_n = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BUS_IDLE;
      fetch_pc   <= RESET_PC;
      stale      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      d_done     <= 1'b0;
      d_readdata <= 32'h0;
    end else begin
      state  <= state_n;
      d_done <= 1'b0;

      if (issue_data) begin
        addr_q  <= d_address;
        rd_q    <= d_read;
        wr_q    <= d_write;
        wdata_q <= wdata_bus;
        be_q    <= d_byteenable;
      end else if (issue_fetch) begin
        addr_q <= fetch_pc;
        rd_q   <= 1'b1;
        wr_q   <= 1'b0;
        be_q   <= 4'hF;
      end else if (xfer_done) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end

      if ((state == BUS_DATA) && xfer_done) begin
        d_done <= 1'b1;
        if (rd_q) d_readdata <= rdata_core;
      end

      if (flush)
        fetch_pc <= flush_pc & 32'hFFFF_FFFC;
      else if (fetch_done && !stale)
        fetch_pc <= fetch_pc + 32'd4;

      if (fetch_done)
        stale <= 1'b0;
      else if (flush && (state == BUS_IFETCH))
        stale <= 1'b1;
    end
  end

endmodule
